// File: rtl/traffic_signal_monitor_if.sv
// traffic_signal_monitor_if: lamp inputs from the controller and checker outputs
// master: drives grn/ylw/red for approaches 1 and 2, observes the checker outputs
// slave:  the monitor; reads lamps, drives armed, fault, fault_code, flash_req, st1, st2
interface traffic_signal_monitor_if;
  logic grn1, ylw1, red1, grn2, ylw2, red2;
  logic armed, fault, flash_req;
  logic [2:0] fault_code;
  logic [1:0] st1, st2;
  modport master (
    output grn1, ylw1, red1, grn2, ylw2, red2,
    input  armed, fault, fault_code, flash_req, st1, st2
  );
  modport slave (
    input  grn1, ylw1, red1, grn2, ylw2, red2,
    output armed, fault, fault_code, flash_req, st1, st2
  );
endinterface

// File: rtl/traffic_signal_monitor.sv
// traffic_signal_monitor: checks two-approach signal lamps for legal sequencing and latches the first fault
// i_clk: clock, i_rst: sync active-high reset
// io_bus: lamps in; armed, fault, fault_code (0 none, 1..7), flash_req, st1/st2 (0 R, 1 G, 2 Y, 3 invalid) out
module traffic_signal_monitor #(
  parameter int CW         = 8,
  parameter int MIN_YLW    = 4,
  parameter int MAX_ALLRED = 16,
  parameter int ARM_CYC    = 3
) (
  input logic i_clk,
  input logic i_rst,
  traffic_signal_monitor_if.slave io_bus
);
  typedef enum logic [1:0] {INIT, RUN, TRIP} state_t;
  localparam int AW = $clog2(ARM_CYC + 1);
  localparam logic [CW-1:0] SAT   = '1;
  localparam logic [CW-1:0] MINY  = CW'(MIN_YLW);
  localparam logic [CW-1:0] ARLIM = CW'(MAX_ALLRED + 1);
  localparam logic [AW-1:0] ARM   = AW'(ARM_CYC);
  // l = {red, ylw, grn}
  function automatic logic [1:0] dec(input logic [2:0] l);
    return l == 3'b100 ? 2'd0 : l == 3'b001 ? 2'd1 : l == 3'b010 ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return v == SAT ? SAT : v + 1'b1;
  endfunction
  state_t        r_st, w_nxt;
  logic [2:0]    r_s1, r_s2, w_l1, w_l2, w_code, r_code;
  logic [1:0]    w_st1, w_st2, w_in1, w_in2, r_p1, r_p2;
  logic [CW-1:0] r_dw1, r_dw2, r_pdw1, r_pdw2, r_ar;
  logic [AW-1:0] r_cln;
  logic          r_flash, r_vld, w_clean, w_nr;
  assign w_l1  = {io_bus.red1, io_bus.ylw1, io_bus.grn1};
  assign w_l2  = {io_bus.red2, io_bus.ylw2, io_bus.grn2};
  assign w_in1 = dec(w_l1);
  assign w_in2 = dec(w_l2);
  assign w_st1 = dec(r_s1);
  assign w_st2 = dec(r_s2);
  // r_p* / r_pdw* hold the previous sample's decode and how long that state had been held,
  // so a Y->R step sees the yellow dwell even though the current dwell has already reloaded
  always_comb begin
    w_nr    = (w_st1 == 2'd1 || w_st1 == 2'd2) && (w_st2 == 2'd1 || w_st2 == 2'd2);
    w_clean = r_vld && w_st1 != 2'd3 && w_st2 != 2'd3 && !w_nr;
    w_code  = w_nr ? 3'd1
      : ((w_st1 == 2'd3 && r_s1 != 3'b0) || (w_st2 == 2'd3 && r_s2 != 3'b0)) ? 3'd2
      : (r_s1 == 3'b0 || r_s2 == 3'b0) ? 3'd3
      : ((r_p1 == 2'd1 && w_st1 == 2'd0) || (r_p2 == 2'd1 && w_st2 == 2'd0)) ? 3'd4
      : ((r_p1 == 2'd2 && w_st1 == 2'd0 && r_pdw1 < MINY) ||
         (r_p2 == 2'd2 && w_st2 == 2'd0 && r_pdw2 < MINY)) ? 3'd5
      : ((r_p1 == 2'd2 && w_st1 == 2'd1) || (r_p1 == 2'd0 && w_st1 == 2'd2) ||
         (r_p2 == 2'd2 && w_st2 == 2'd1) || (r_p2 == 2'd0 && w_st2 == 2'd2)) ? 3'd6
      : (r_ar >= ARLIM) ? 3'd7 : 3'd0;
    w_nxt = (r_st == INIT && w_clean && r_cln + 1'b1 == ARM) ? RUN
      : (r_st == RUN && w_code != 3'd0) ? TRIP : r_st;
  end
  // the sample stage resets to both-red so outputs read 0; r_vld keeps that reset sample
  // from counting as a clean arming sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st    <= INIT;
      r_s1    <= 3'b100;
      r_s2    <= 3'b100;
      r_p1    <= 2'd0;
      r_p2    <= 2'd0;
      r_dw1   <= '0;
      r_dw2   <= '0;
      r_pdw1  <= '0;
      r_pdw2  <= '0;
      r_ar    <= '0;
      r_cln   <= '0;
      r_code  <= 3'd0;
      r_flash <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_st    <= w_nxt;
      r_s1    <= w_l1;
      r_s2    <= w_l2;
      r_p1    <= w_st1;
      r_p2    <= w_st2;
      r_dw1   <= w_in1 != w_st1 ? CW'(1) : inc(r_dw1);
      r_dw2   <= w_in2 != w_st2 ? CW'(1) : inc(r_dw2);
      r_pdw1  <= r_dw1;
      r_pdw2  <= r_dw2;
      r_ar    <= (w_in1 == 2'd0 && w_in2 == 2'd0) ? inc(r_ar) : '0;
      r_cln   <= (r_st == INIT && w_clean) ? r_cln + 1'b1 : '0;
      r_code  <= r_st == RUN ? w_code : r_code;
      r_flash <= r_st == TRIP;
      r_vld   <= 1'b1;
    end
  end
  assign io_bus.armed      = r_st == RUN;
  assign io_bus.fault      = r_st == TRIP;
  assign io_bus.fault_code = r_code;
  assign io_bus.flash_req  = r_flash;
  assign io_bus.st1        = w_st1;
  assign io_bus.st2        = w_st2;
endmodule
